reg_dump_tx: RTL and testbench

Debug read-out engine for the single-cycle ARM datapath. When it receives a start pulse, it walks register-file addresses 0 to NUM_REGS-1 through a dedicated read port. It captures each word and transmits it as W/8 UART 8N1 frames, LSB byte first and LSB bit first. It is the reader/transmitter counterpart to the register file's write side, and it gives bench and board visibility of R0–R14 without touching the datapath.

---
 rtl/reg_dump_tx.sv | 188 ++++++++++++++++++
 tb/tb_reg_dump_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks register-file addresses 0..NUM_REGS-1 after a start
// request, captures each word and sends it as W/8 UART 8N1 frames
// (LSB byte first, LSB bit first).
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   i_start  one-cycle dump request, honoured only while idle
//   o_addr   register-file read-port address
//   i_rd     combinational read data for o_addr
//   o_tx     UART line, idle high (registered)
//   o_busy   high whenever a dump is accepted or in progress (registered)
//   o_done   one-cycle pulse after the final stop bit (registered)
//
// Parameter limits: W a multiple of 8, NUM_REGS 1..16, CLKS_PER_BIT >= 2.
module reg_dump_tx #(
    parameter int unsigned W            = 32,
    parameter int unsigned NUM_REGS     = 15,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    output logic [3:0]   o_addr,
    input  logic [W-1:0] i_rd,
    output logic         o_tx,
    output logic         o_busy,
    output logic         o_done
);

    localparam int unsigned BYTES  = W / 8;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [3:0]        ADDR_LAST = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state_q,  state_d;
    logic              start_q,  start_d;
    logic [3:0]        addr_q,   addr_d;
    logic [W-1:0]      shift_q,  shift_d;
    logic [BYTE_W-1:0] byte_q,   byte_d;
    logic [2:0]        bit_q,    bit_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              tx_q,     tx_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic              bit_end;

    // State and datapath registers; reset forces the line back to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            addr_q  <= 4'd0;
            shift_q <= '0;
            byte_q  <= '0;
            bit_q   <= 3'd0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        addr_d  = addr_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        bit_end = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                // The request is held one cycle in start_q before LOAD; a
                // request seen while already pending is not re-latched.
                start_d = i_start & ~start_q;
                if (start_q) begin
                    addr_d  = 4'd0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // Word is frozen here; later register writes do not leak in.
                shift_d = i_rd;
                byte_d  = '0;
                cnt_d   = '0;
                tx_d    = 1'b0;
                state_d = S_START;
            end

            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Shift after every bit, including the eighth, so the next
                    // byte is already sitting in bit 0 for the following frame.
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d  = shift_q[1];
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_q != BYTE_LAST) begin
                        byte_d  = byte_q + BYTE_W'(1);
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else if (addr_q != ADDR_LAST) begin
                        addr_d  = addr_q + 4'd1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                addr_d  = 4'd0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign o_addr = addr_q;
    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench for reg_dump_tx: a one-register instance and a full
// fifteen-register instance, both at four clocks per bit.
`timescale 1ns/1ps
module tb_reg_dump_tx;

    localparam int W        = 32;
    localparam int C        = 4;
    localparam int FULL_N   = 15;
    localparam int FRAME    = 10 * C;
    localparam int WORD_CYC = 4 * FRAME + 1;
    localparam int DUMP_CYC = FULL_N * 4 * FRAME + FULL_N - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         s1_start = 1'b0;
    logic [3:0]   s1_addr;
    logic [W-1:0] s1_rd;
    logic         s1_tx, s1_busy, s1_done;

    logic         f_start = 1'b0;
    logic [3:0]   f_addr;
    logic [W-1:0] f_rd;
    logic         f_tx, f_busy, f_done;

    logic [W-1:0] regs  [16];
    logic [W-1:0] exp_w [FULL_N];

    int cyc       = 0;
    int checks    = 0;
    int failures  = 0;
    int done1_cnt = 0;
    int donef_cnt = 0;
    int e, f0, dcyc, bad, base, w;

    assign s1_rd = 32'hA5C3_0F81;
    assign f_rd  = regs[f_addr];

    reg_dump_tx #(.W(W), .NUM_REGS(1), .CLKS_PER_BIT(C)) u_one (
        .clk(clk), .rst(rst), .i_start(s1_start), .o_addr(s1_addr),
        .i_rd(s1_rd), .o_tx(s1_tx), .o_busy(s1_busy), .o_done(s1_done)
    );

    reg_dump_tx #(.W(W), .NUM_REGS(FULL_N), .CLKS_PER_BIT(C)) u_full (
        .clk(clk), .rst(rst), .i_start(f_start), .o_addr(f_addr),
        .i_rd(f_rd), .o_tx(f_tx), .o_busy(f_busy), .o_done(f_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s1_done === 1'b1) done1_cnt <= done1_cnt + 1;
        if (f_done === 1'b1)  donef_cnt <= donef_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic txsel(input bit which);
        return which ? f_tx : s1_tx;
    endfunction

    // Caller is at a negedge; returns with e = edge that sampled i_start.
    task automatic kick(input bit which, output int e_out);
        if (which) f_start = 1'b1;
        else       s1_start = 1'b1;
        @(negedge clk);
        f_start  = 1'b0;
        s1_start = 1'b0;
        e_out    = cyc;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_at(input int t);
        wait_until(t);
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
    endtask

    // Checks every cycle of one 8N1 frame against the expected byte.
    task automatic rx_frame(input bit which, input logic [7:0] exp_b, input string tag,
                            output int fall_at);
        int waited;
        int errs;
        logic [7:0] got;
        logic b, want;
        waited = 0;
        errs   = 0;
        got    = '0;
        do begin
            @(negedge clk);
            waited++;
        end while (txsel(which) !== 1'b0 && waited < 400);
        fall_at = cyc;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < C; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                b = txsel(which);
                if (k == 0)      want = 1'b0;
                else if (k == 9) want = 1'b1;
                else             want = exp_b[k-1];
                if (b !== want) errs++;
                if (c == C / 2 && k >= 1 && k <= 8) got[k-1] = b;
            end
        end
        check({tag, " byte"}, 64'(got), 64'(exp_b));
        check({tag, " shape"}, 64'(errs), 64'd0);
    endtask

    // Receives a whole 15-word dump from u_full and checks o_done timing.
    task automatic full_dump(input string tag, input int e_in);
        int fall0, fa, wt;
        fall0 = -1;
        base  = donef_cnt;
        for (int n = 0; n < FULL_N; n++) begin
            for (int bi = 0; bi < 4; bi++) begin
                rx_frame(1'b1, 8'(exp_w[n] >> (8 * bi)),
                         $sformatf("%s r%0d b%0d", tag, n, bi), fa);
                if (n == 0 && bi == 0) fall0 = fa;
            end
        end
        check({tag, " first fall"}, 64'(fall0), 64'(e_in + 2));
        wt = 0;
        while (f_done !== 1'b1 && wt < 10) begin
            @(negedge clk);
            wt++;
        end
        dcyc = cyc;
        check({tag, " done time"}, 64'(dcyc - fall0), 64'(DUMP_CYC));
        @(negedge clk);
        check({tag, " done width"}, 64'(f_done), 64'd0);
        check({tag, " busy after"}, 64'(f_busy), 64'd0);
        check({tag, " done count"}, 64'(donef_cnt - base), 64'd1);
    endtask

    initial begin
        for (int n = 0; n < 16; n++) regs[n] = 32'(32'h1111_1111 * n);
        for (int n = 0; n < FULL_N; n++) exp_w[n] = regs[n];

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst tx",   64'(f_tx),   64'd1);
        check("rst busy", 64'(f_busy), 64'd0);
        check("rst done", 64'(f_done), 64'd0);
        check("rst addr", 64'(f_addr), 64'd0);
        check("rst s1 tx", 64'(s1_tx), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (f_tx !== 1'b1 || f_busy !== 1'b0 || f_done !== 1'b0 || f_addr !== 4'd0) bad++;
            if (s1_tx !== 1'b1 || s1_busy !== 1'b0 || s1_done !== 1'b0) bad++;
        end
        check("idle hold", 64'(bad), 64'd0);

        // Single word on the one-register instance.
        kick(1'b0, e);
        check("one busy at E", 64'(s1_busy), 64'd0);
        @(negedge clk);
        check("one busy at E+1", 64'(s1_busy), 64'd1);
        check("one addr load",   64'(s1_addr), 64'd0);
        rx_frame(1'b0, 8'h81, "one b0", f0);
        check("one fall", 64'(f0), 64'(e + 2));
        rx_frame(1'b0, 8'h0F, "one b1", w);
        rx_frame(1'b0, 8'hC3, "one b2", w);
        rx_frame(1'b0, 8'hA5, "one b3", w);
        w = 0;
        while (s1_done !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("one done time", 64'(cyc - f0), 64'd160);
        @(negedge clk);
        check("one done width", 64'(s1_done), 64'd0);
        check("one busy after", 64'(s1_busy), 64'd0);
        check("one done count", 64'(done1_cnt), 64'd1);

        // Undisturbed full dump.
        kick(1'b1, e);
        full_dump("full", e);

        // Start in the IDLE cycle right after DONE is accepted; during this
        // dump further requests land in LOAD, mid-DATA, R1 LOAD and DONE.
        kick(1'b1, e);
        fork
            full_dump("rej", e);
            begin
                pulse_at(e + 1);
                pulse_at(e + 2 + 20);
                pulse_at(e + 2 + WORD_CYC - 1);
                pulse_at(e + 2 + DUMP_CYC);
            end
        join
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (f_busy !== 1'b0 || f_tx !== 1'b1) bad++;
        end
        check("rej done-cycle start ignored", 64'(bad), 64'd0);

        // Capture freeze on R1; a later register written before its LOAD.
        regs[1]  = 32'h0102_0304;
        exp_w[1] = 32'h0102_0304;
        exp_w[2] = 32'h0BAD_F00D;
        kick(1'b1, e);
        fork
            full_dump("frz", e);
            begin
                wait_until(e + 2 + WORD_CYC + FRAME + 20);
                regs[1] = 32'hDEAD_BEEF;
                regs[2] = 32'h0BAD_F00D;
            end
        join

        // Reset during R5's data bits (bit 1 of 0x55 is low).
        regs[0] = 32'h1122_3344;
        regs[5] = 32'h5555_5555;
        kick(1'b1, e);
        wait_until(e + 2 + 5 * WORD_CYC + C + C);
        check("r5 bit1 low", 64'(f_tx), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("mid rst tx",   64'(f_tx),   64'd1);
        check("mid rst busy", 64'(f_busy), 64'd0);
        check("mid rst addr", 64'(f_addr), 64'd0);
        check("mid rst done", 64'(f_done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        base = donef_cnt;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (f_tx !== 1'b1 || f_busy !== 1'b0) bad++;
        end
        check("post rst idle", 64'(bad), 64'd0);
        check("post rst no done", 64'(donef_cnt - base), 64'd0);
        kick(1'b1, e);
        @(negedge clk);
        check("restart addr", 64'(f_addr), 64'd0);
        check("restart busy", 64'(f_busy), 64'd1);
        rx_frame(1'b1, 8'h44, "restart b0", f0);
        check("restart fall", 64'(f0), 64'(e + 2));
        rx_frame(1'b1, 8'h33, "restart b1", w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
